// File: rtl/swap_mode_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : swap_mode_seq_if
//  Description : Control bundle between the video timing/control side and the
//                frame-synchronous swap-mode sequencer.
//                master : timing generator / host side (drives vsync + requests)
//                slave  : swap_mode_seq (drives mode select and status pulses)
//  Signals     : vid_pVSync, mode_req[1:0], auto_en, step_frames[CNT_W-1:0]
//                mode_out[1:0], frame_start, seq_active, step_pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface swap_mode_seq_if #(
  parameter int CNT_W = 8
);
  logic             vid_pVSync;
  logic [1:0]       mode_req;
  logic             auto_en;
  logic [CNT_W-1:0] step_frames;
  logic [1:0]       mode_out;
  logic             frame_start;
  logic             seq_active;
  logic             step_pulse;

  modport master (
    output vid_pVSync, mode_req, auto_en, step_frames,
    input  mode_out, frame_start, seq_active, step_pulse
  );

  modport slave (
    input  vid_pVSync, mode_req, auto_en, step_frames,
    output mode_out, frame_start, seq_active, step_pulse
  );
endinterface
`default_nettype wire

// File: rtl/swap_mode_seq.sv
`default_nettype none
// ============================================================================
//  Module      : swap_mode_seq
//  Description : Frame-synchronous mode controller for the RGB channel-swap
//                stage. Mode only changes on a vsync assertion edge. Manual
//                operation passes mode_req through; auto operation steps the
//                mode every max(step_frames,1) frames.
//  Ports       : clk, rst (sync, active-high)
//                bus (swap_mode_seq_if.slave): vid_pVSync, mode_req, auto_en,
//                step_frames in; mode_out, frame_start, seq_active,
//                step_pulse out
//  Parameters  : VSYNC_POL - active level of vid_pVSync
//                CNT_W     - frame counter / step_frames width
//  Macro       : SWAP_SEQ_RANDOM_EN - pseudo-random auto steps from an 8-bit
//                LFSR instead of the linear 00->01->10->11 sequence
//  Revision    : 1.0 - initial release
// ============================================================================
module swap_mode_seq #(
  parameter bit VSYNC_POL = 1'b1,
  parameter int CNT_W     = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  swap_mode_seq_if.slave bus
);

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, eff_m1;
  logic [1:0]       mode, mode_nxt, step_mode;
  logic             step_nxt;
  logic             vs_d, armed, vs_act, vs_edge;
  logic             frame_start, step_pulse, seq_active;

  assign vs_act = (bus.vid_pVSync == VSYNC_POL);
  // vs_d starts at the inactive level, so without 'armed' a vsync already
  // active at reset release would look like an edge. 'armed' waits until an
  // inactive sample has really been seen.
  assign vs_edge = vs_act && (vs_d != VSYNC_POL) && armed;

  // step_frames of 0 behaves as 1; compare against eff-1 so cnt never wraps.
  assign eff_m1 = (bus.step_frames == '0) ? '0 : bus.step_frames - CNT_W'(1);

`ifdef SWAP_SEQ_RANDOM_EN
  logic [7:0] lfsr;
  logic       lfsr_fb;

  // Fibonacci taps 8,6,5,4
  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  // Bump the candidate when it equals the current mode so every step changes it.
  assign step_mode = (lfsr[1:0] == mode) ? mode + 2'd1 : lfsr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else if (step_nxt) begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end
`else
  assign step_mode = mode + 2'd1;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode;
    step_nxt  = 1'b0;
    if (vs_edge) begin
      case (state)
        ST_MANUAL: begin
          mode_nxt = bus.mode_req;
          if (bus.auto_en) begin
            state_nxt = ST_AUTO;
            cnt_nxt   = '0;
          end
        end
        ST_AUTO: begin
          if (!bus.auto_en) begin
            state_nxt = ST_MANUAL;
            cnt_nxt   = '0;
            mode_nxt  = bus.mode_req;
          end else if (cnt >= eff_m1) begin
            cnt_nxt  = '0;
            mode_nxt = step_mode;
            step_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: state_nxt = ST_MANUAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_MANUAL;
      cnt         <= '0;
      mode        <= 2'b00;
      vs_d        <= ~VSYNC_POL;
      armed       <= 1'b0;
      frame_start <= 1'b0;
      step_pulse  <= 1'b0;
      seq_active  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      mode        <= mode_nxt;
      vs_d        <= bus.vid_pVSync;
      armed       <= armed | ~vs_act;
      frame_start <= vs_edge;
      step_pulse  <= step_nxt;
      seq_active  <= (state_nxt == ST_AUTO);
    end
  end

  assign bus.mode_out    = mode;
  assign bus.frame_start = frame_start;
  assign bus.step_pulse  = step_pulse;
  assign bus.seq_active  = seq_active;

endmodule
`default_nettype wire

// File: tb/tb_swap_mode_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_swap_mode_seq
//  Description : Self-checking bench for swap_mode_seq. Directed frame
//                scenarios followed by randomized frames, all compared every
//                cycle against a frame-level behavioural model.
//  Macro       : SWAP_SEQ_RANDOM_EN selects the LFSR step rule in the model
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_swap_mode_seq;

  localparam bit c_pol = 1'b1;
  localparam int c_cnt_w = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  swap_mode_seq_if #(.CNT_W(c_cnt_w)) ifc ();

  swap_mode_seq #(.VSYNC_POL(c_pol), .CNT_W(c_cnt_w)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_fs  = 0;
  int n_sp  = 0;

  // model state
  bit m_vs_prev, m_seen_idle, m_auto, m_fs, m_sp;
  int m_frames, m_mode;
  int m_lfsr;
  int obs_prev_mode;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int next_mode(input int cur);
    int cand, fb;
`ifdef SWAP_SEQ_RANDOM_EN
    cand = m_lfsr % 4;
    fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    m_lfsr = ((m_lfsr * 2) + fb) % 256;
    return (cand == cur) ? (cur + 1) % 4 : cand;
`else
    cand = 0;
    fb = 0;
    return (cur + 1) % 4;
`endif
  endfunction

  // Frame-level model: 'm_frames' counts frames already spent at the current
  // auto mode; a step happens when that count reaches the step length.
  task automatic model_clock(input bit r, input bit vs, input int mr, input bit ae, input int sf);
    bit active, is_edge;
    int len;
    if (r) begin
      m_vs_prev = 1'b0; m_seen_idle = 1'b0; m_auto = 1'b0;
      m_fs = 1'b0; m_sp = 1'b0; m_frames = 0; m_mode = 0; m_lfsr = 'hA5;
      return;
    end
    active  = (vs == c_pol);
    is_edge = active && !m_vs_prev && m_seen_idle;
    m_vs_prev = active;
    if (!active) m_seen_idle = 1'b1;
    m_fs = is_edge;
    m_sp = 1'b0;
    if (is_edge) begin
      if (!ae) begin
        m_auto = 1'b0; m_frames = 0; m_mode = mr;
      end else if (!m_auto) begin
        m_auto = 1'b1; m_frames = 0; m_mode = mr;
      end else begin
        len = (sf == 0) ? 1 : sf;
        m_frames = m_frames + 1;
        if (m_frames >= len) begin
          m_frames = 0; m_mode = next_mode(m_mode); m_sp = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit vs_on, input logic [1:0] mr, input bit ae, input logic [7:0] sf);
    bit vs;
    vs = vs_on ? c_pol : ~c_pol;
    rst = r;
    ifc.vid_pVSync  = vs;
    ifc.mode_req    = mr;
    ifc.auto_en     = ae;
    ifc.step_frames = sf;
    @(posedge clk);
    model_clock(r, vs, int'(mr), ae, int'(sf));
    #1;
    chk_val("mode_out", 32'(ifc.mode_out), 32'(m_mode));
    chk_val("frame_start", 32'(ifc.frame_start), 32'(m_fs));
    chk_val("step_pulse", 32'(ifc.step_pulse), 32'(m_sp));
    chk_val("seq_active", 32'(ifc.seq_active), 32'(m_auto));
    if (ifc.step_pulse === 1'b1) begin
      chk_val("step_changes_mode", 32'(int'(ifc.mode_out) != obs_prev_mode), 32'd1);
      n_sp++;
    end
    if (ifc.frame_start === 1'b1) n_fs++;
    obs_prev_mode = int'(ifc.mode_out);
  endtask

  // One frame: inputs given here are presented on the edge cycle only; all
  // other cycles carry random noise that must be ignored.
  task automatic frame(input logic [1:0] mr, input bit ae, input logic [7:0] sf,
                       input int act, input int idle);
    cycle(1'b0, 1'b1, mr, ae, sf);
    for (int i = 1; i < act; i++)
      cycle(1'b0, 1'b1, 2'($urandom), 1'($urandom), 8'($urandom));
    for (int i = 0; i < idle; i++)
      cycle(1'b0, 1'b0, 2'($urandom), 1'($urandom), 8'($urandom));
  endtask

  initial begin
    int sp0;
    obs_prev_mode = 0;

    // reset, then manual pass-through of 10
    cycle(1'b1, 1'b0, 2'b10, 1'b0, 8'd0);
    cycle(1'b1, 1'b0, 2'b10, 1'b0, 8'd0);
    chk_val("reset_mode", 32'(ifc.mode_out), 32'd0);
    cycle(1'b0, 1'b0, 2'b10, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 2'b10, 1'b0, 8'd0);
    frame(2'b10, 1'b0, 8'd0, 2, 4);
    chk_val("manual_10", 32'(ifc.mode_out), 32'd2);
    chk_val("one_fs", 32'(n_fs), 32'd1);

    // mode_req 01 -> 11 between edges does nothing; 11 appears after the edge
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'b01, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'b11, 1'b0, 8'd0);
    chk_val("no_edge_hold", 32'(ifc.mode_out), 32'd2);
    frame(2'b11, 1'b0, 8'd0, 1, 3);
    chk_val("manual_11", 32'(ifc.mode_out), 32'd3);

    // auto, step every 3 frames over 13 frames -> 4 steps
    sp0 = n_sp;
    for (int f = 0; f < 13; f++) frame(2'b00, 1'b1, 8'd3, 2, 3);
    chk_val("auto3_steps", 32'(n_sp - sp0), 32'd4);
`ifndef SWAP_SEQ_RANDOM_EN
    chk_val("auto3_final", 32'(ifc.mode_out), 32'd0);
`endif

    // step_frames = 0 -> step on every edge
    sp0 = n_sp;
    for (int f = 0; f < 5; f++) frame(2'b00, 1'b1, 8'd0, 1, 2);
    chk_val("sf0_steps", 32'(n_sp - sp0), 32'd5);

    // reach cnt = 5 with step length 8, then shrink to 2
    frame(2'b01, 1'b0, 8'd8, 1, 2);
    frame(2'b01, 1'b1, 8'd8, 1, 2);
    sp0 = n_sp;
    for (int f = 0; f < 5; f++) frame(2'b01, 1'b1, 8'd8, 1, 2);
    chk_val("cnt5_no_step", 32'(n_sp - sp0), 32'd0);
    frame(2'b01, 1'b1, 8'd2, 1, 2);
    chk_val("shrink_step", 32'(n_sp - sp0), 32'd1);

    // reset mid-count
    frame(2'b01, 1'b1, 8'd8, 1, 2);
    cycle(1'b1, 1'b0, 2'b11, 1'b1, 8'd8);
    chk_val("rst_mid_mode", 32'(ifc.mode_out), 32'd0);
    chk_val("rst_mid_active", 32'(ifc.seq_active), 32'd0);

    // vsync held active through reset release: no frame_start until re-edge
    cycle(1'b1, 1'b1, 2'b10, 1'b0, 8'd0);
    sp0 = n_fs;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'b10, 1'b0, 8'd0);
    chk_val("held_no_fs", 32'(n_fs - sp0), 32'd0);
    cycle(1'b0, 1'b0, 2'b10, 1'b0, 8'd0);
    frame(2'b10, 1'b0, 8'd0, 1, 2);
    chk_val("held_re_edge_fs", 32'(n_fs - sp0), 32'd1);

    // randomized frames
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 19) == 0) begin
        cycle(1'b1, 1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
        cycle(1'b0, 1'b0, 2'($urandom), 1'($urandom), 8'($urandom));
      end
      frame(2'($urandom), $urandom_range(0, 3) != 0, 8'($urandom_range(0, 4)),
            $urandom_range(1, 3), $urandom_range(1, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
